i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 228 ++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
`timescale 1ns/1ps
// i2c_slave
// 7-bit-address I2C target. It has no clock stretching, and it only pulls sda
// low or releases it (open drain). All logic runs on clk100mhz. The bus pins
// go through 2-flop synchronizers. Edges are taken from the synchronized value
// and its previous sample, so each bus event takes effect at most 3 clocks
// after the pin moves.
//
// Ports
//   clk100mhz   system clock, rising edge
//   res         asynchronous active-low reset
//   scl         bus clock from the master, input only
//   sda         bus data, open drain (0 or Z)
//   tx_data     byte sent to the master on reads
//   tx_req      1-cycle pulse when tx_data is latched into the shift register
//   rx_data     last byte received on a write
//   rx_valid    1-cycle pulse, one clock after rx_data is updated
//   busy        high from START until STOP
//   addr_match  high from address ACK until STOP or repeated START
//   state_dbg   current FSM state encoding
//
// Data-side handshake: tx_req and rx_valid are strobes with no back-pressure.
// The user keeps tx_data valid before the read byte starts or before the
// master's ACK. The user captures rx_data while rx_valid is high, or any time
// before the next byte completes.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h4C
) (
    input  logic       clk100mhz,
    input  logic       res,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       addr_match,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WR_DATA   = 3'd3,
        WR_ACK    = 3'd4,
        RD_DATA   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic       rw, rw_n;
    logic       sda_low, sda_low_n;
    logic       ack_seen, ack_seen_n;
    logic       rx_pend, rx_pend_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n, tx_req_n, busy_n, addr_match_n;
    logic [7:0] shift_in;

    // The synchronizers reset to 1 (idle bus) so that reset release gives no false START/STOP.
    logic scl_s1, scl_s2, scl_prev;
    logic sda_s1, sda_s2, sda_prev;

    always_ff @(posedge clk100mhz or negedge res) begin
        if (!res) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_prev <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_prev <= 1'b1;
        end else begin
            scl_s1 <= scl;  scl_s2 <= scl_s1; scl_prev <= scl_s2;
            sda_s1 <= sda;  sda_s2 <= sda_s1; sda_prev <= sda_s2;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_s2 & ~scl_prev;
    assign scl_fall  = ~scl_s2 &  scl_prev;
    assign start_det =  scl_s2 &  scl_prev &  sda_prev & ~sda_s2;
    assign stop_det  =  scl_s2 &  scl_prev & ~sda_prev &  sda_s2;

    // Gating the drive with res releases the line at once, without waiting for a clock.
    assign sda       = (sda_low && res) ? 1'b0 : 1'bz;
    assign state_dbg = state;

    always_ff @(posedge clk100mhz or negedge res) begin
        if (!res) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            rw         <= 1'b0;
            sda_low    <= 1'b0;
            ack_seen   <= 1'b0;
            rx_pend    <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            busy       <= 1'b0;
            addr_match <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            rw         <= rw_n;
            sda_low    <= sda_low_n;
            ack_seen   <= ack_seen_n;
            rx_pend    <= rx_pend_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            tx_req     <= tx_req_n;
            busy       <= busy_n;
            addr_match <= addr_match_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        rw_n         = rw;
        sda_low_n    = sda_low;
        ack_seen_n   = ack_seen;
        rx_pend_n    = 1'b0;
        rx_data_n    = rx_data;
        rx_valid_n   = rx_pend;
        tx_req_n     = 1'b0;
        busy_n       = busy;
        addr_match_n = addr_match;
        shift_in     = {shift[6:0], sda_s2};

        // Bus conditions win over any scl edge seen in the same cycle.
        if (stop_det) begin
            state_n      = IDLE;
            bit_cnt_n    = 3'd0;
            shift_n      = 8'h00;
            sda_low_n    = 1'b0;
            ack_seen_n   = 1'b0;
            busy_n       = 1'b0;
            addr_match_n = 1'b0;
        end else if (start_det) begin
            state_n      = ADDR;
            bit_cnt_n    = 3'd0;
            shift_n      = 8'h00;
            sda_low_n    = 1'b0;
            ack_seen_n   = 1'b0;
            busy_n       = 1'b1;
            addr_match_n = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_n   = shift_in;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (shift_in[7:1] == SLAVE_ADDR) begin
                                state_n      = ADDR_ACK;
                                rw_n         = shift_in[0];
                                addr_match_n = 1'b1;
                            end else begin
                                state_n = WAIT_STOP;
                            end
                        end
                    end
                end
                // First fall (end of 8th bit) pulls sda low; second fall (end of ACK) releases it.
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_low) begin
                            sda_low_n = 1'b1;
                        end else if (state == WR_ACK || !rw) begin
                            sda_low_n = 1'b0;
                            state_n   = WR_DATA;
                        end else begin
                            state_n   = RD_DATA;
                            shift_n   = tx_data;
                            tx_req_n  = 1'b1;
                            sda_low_n = ~tx_data[7];
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_n   = shift_in;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_n = shift_in;
                            rx_pend_n = 1'b1;
                            state_n   = WR_ACK;
                        end
                    end
                end
                // bit_cnt counts master sample edges. It wraps to 0 after the 8th bit,
                // and the falling edge that follows hands the line over for the ACK.
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_low_n = 1'b0;
                            state_n   = RD_ACK;
                        end else begin
                            shift_n   = {shift[6:0], 1'b0};
                            sda_low_n = ~shift[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s2) state_n = WAIT_STOP;
                        else        ack_seen_n = 1'b1;
                    end else if (scl_fall && ack_seen) begin
                        ack_seen_n = 1'b0;
                        state_n    = RD_DATA;
                        shift_n    = tx_data;
                        tx_req_n   = 1'b1;
                        sda_low_n  = ~tx_data[7];
                    end
                end
                WAIT_STOP: sda_low_n = 1'b0;
                default:   state_n   = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int T = 100;  // quarter-ish bus phase in ns (10 system clocks)
    localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_RD_DATA = 3'd5, S_WAIT_STOP = 3'd7;

    // ---------------- clock / reset ----------------
    logic clk100mhz = 1'b0;
    always #5 clk100mhz = ~clk100mhz;

    logic       res;
    logic       scl;
    logic       m_sda_oe;
    logic [7:0] tx_data;
    wire        sda_bus;
    logic       tx_req, rx_valid, busy, addr_match;
    logic [7:0] rx_data;
    logic [2:0] state_dbg;

    pullup (sda_bus);
    assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;

    i2c_slave #(.SLAVE_ADDR(7'h4C)) dut (
        .clk100mhz (clk100mhz),
        .res       (res),
        .scl       (scl),
        .sda       (sda_bus),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .addr_match(addr_match),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    int rx_valid_cnt = 0;
    int tx_req_cnt   = 0;
    int slave_low_cnt = 0;
    int match_cnt    = 0;

    always @(negedge clk100mhz) begin
        if (tx_req) tx_req_cnt++;
        if (addr_match) match_cnt++;
        if (sda_bus === 1'b0 && !m_sda_oe) slave_low_cnt++;
        if (rx_valid) begin
            rx_valid_cnt++;
            if (exp_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
            else                   check("rx_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic i2c_start();
        m_sda_oe = 1'b0; #T;
        scl = 1'b1;      #T;
        m_sda_oe = 1'b1; #T;
        scl = 1'b0;      #T;
    endtask

    task automatic i2c_stop();
        m_sda_oe = 1'b1; #T;
        scl = 1'b1;      #T;
        m_sda_oe = 1'b0; #T;
    endtask

    task automatic send_bit(input logic b, output logic seen);
        m_sda_oe = ~b; #T;
        scl = 1'b1;    #(T/2);
        seen = sda_bus; #(T/2);
        scl = 1'b0;    #T;
    endtask

    task automatic recv_bit(output logic b);
        logic s;
        send_bit(1'b1, s);
        b = s;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(d[i], s);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack,
                             input logic [7:0] next_tx, output logic seen9);
        logic b;
        logic [7:0] tmp;
        tmp = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            tmp[i] = b;
        end
        d = tmp;
        tx_data = next_tx;
        send_bit(nack, seen9);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic ack, seen9, s;
        logic [7:0] d, d2;
        int rv0, tr0, sl0, mc0;

        res = 1'b0; scl = 1'b1; m_sda_oe = 1'b0; tx_data = 8'h00;
        #25;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_match", {31'd0, addr_match}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_req", {31'd0, tx_req}, 32'd0);
        check("rst_sda", {31'd0, sda_bus}, 32'd1);
        check("rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        res = 1'b1; #T;

        // Write 0x55 to 0x4C
        rv0 = rx_valid_cnt;
        i2c_start();
        check("wr_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back(8'h55);
        write_byte(8'h98, ack);
        check("wr_addr_ack", {31'd0, ack}, 32'd0);
        check("wr_match", {31'd0, addr_match}, 32'd1);
        write_byte(8'h55, ack);
        check("wr_data_ack", {31'd0, ack}, 32'd0);
        check("wr_rx_data", {24'd0, rx_data}, 32'h55);
        check("wr_rx_pulses", rx_valid_cnt - rv0, 32'd1);
        i2c_stop();
        check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
        check("wr_match_after_stop", {31'd0, addr_match}, 32'd0);

        // Address mismatch (0x48)
        #T;
        rv0 = rx_valid_cnt; sl0 = slave_low_cnt; mc0 = match_cnt;
        i2c_start();
        write_byte(8'h90, ack);
        check("mm_addr_nack", {31'd0, ack}, 32'd1);
        write_byte(8'h55, ack);
        check("mm_data_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("mm_no_low", slave_low_cnt - sl0, 32'd0);
        check("mm_no_rx", rx_valid_cnt - rv0, 32'd0);
        check("mm_no_match", match_cnt - mc0, 32'd0);

        // Single read with NACK
        #T;
        tx_data = 8'hA5; tr0 = tx_req_cnt;
        i2c_start();
        write_byte(8'h99, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(d, 1'b1, 8'hA5, seen9);
        check("rd_byte", {24'd0, d}, 32'hA5);
        check("rd_9th_released", {31'd0, seen9}, 32'd1);
        check("rd_tx_req", tx_req_cnt - tr0, 32'd1);
        check("rd_wait_stop", {29'd0, state_dbg}, {29'd0, S_WAIT_STOP});
        i2c_stop();
        check("rd_busy_after_stop", {31'd0, busy}, 32'd0);

        // Burst read: ACK then NACK
        #T;
        tx_data = 8'h3C; tr0 = tx_req_cnt;
        i2c_start();
        write_byte(8'h99, ack);
        check("brd_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(d, 1'b0, 8'hC3, seen9);
        read_byte(d2, 1'b1, 8'h00, seen9);
        check("brd_byte0", {24'd0, d}, 32'h3C);
        check("brd_byte1", {24'd0, d2}, 32'hC3);
        check("brd_tx_req", tx_req_cnt - tr0, 32'd2);
        i2c_stop();

        // Repeated START after 4 write data bits, then read address
        #T;
        rv0 = rx_valid_cnt; tx_data = 8'h5A;
        i2c_start();
        write_byte(8'h98, ack);
        check("rs_addr_ack", {31'd0, ack}, 32'd0);
        send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b0, s);
        i2c_start();
        check("rs_match_cleared", {31'd0, addr_match}, 32'd0);
        check("rs_state_addr", {29'd0, state_dbg}, {29'd0, S_ADDR});
        write_byte(8'h99, ack);
        check("rs_read_ack", {31'd0, ack}, 32'd0);
        check("rs_match", {31'd0, addr_match}, 32'd1);
        check("rs_rd_data", {29'd0, state_dbg}, {29'd0, S_RD_DATA});
        read_byte(d, 1'b1, 8'h00, seen9);
        check("rs_byte", {24'd0, d}, 32'h5A);
        i2c_stop();
        check("rs_no_rx", rx_valid_cnt - rv0, 32'd0);

        // Reset during address ACK, then a clean write
        #T;
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] a;
            a = 8'h98;
            send_bit(a[i], s);
        end
        m_sda_oe = 1'b0; #T;
        scl = 1'b1; #(T/2);
        check("rst_ack_low", {31'd0, sda_bus}, 32'd0);
        res = 1'b0; #1;
        check("rst_ack_released", {31'd0, sda_bus}, 32'd1);
        check("rst_ack_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        check("rst_ack_busy", {31'd0, busy}, 32'd0);
        #(T/2 - 1);
        scl = 1'b0; #T;
        res = 1'b1; #T;
        exp_q.push_back(8'h12);
        i2c_start();
        write_byte(8'h98, ack);
        check("post_rst_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h12, ack);
        check("post_rst_data_ack", {31'd0, ack}, 32'd0);
        check("post_rst_rx_data", {24'd0, rx_data}, 32'h12);
        i2c_stop();

        #T;
        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
